// File: rtl/otter_pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : otter_pipe_ctrl_pkg
//  Description : Shared types and constants for the OTTER pipeline hazard
//                controller (opcodes, instruction layout, forwarding selects,
//                controller states, PC-source encodings).
//  Revision    : 1.0 - initial release
// ============================================================================
package otter_pipe_ctrl_pkg;

   typedef enum logic [6:0] {
      OP_LUI    = 7'b0110111,
      OP_AUIPC  = 7'b0010111,
      OP_JAL    = 7'b1101111,
      OP_JALR   = 7'b1100111,
      OP_BRANCH = 7'b1100011,
      OP_LOAD   = 7'b0000011,
      OP_STORE  = 7'b0100011,
      OP_IMM    = 7'b0010011,
      OP_REG    = 7'b0110011,
      OP_SYS    = 7'b1110011
   } opcode_t;

   typedef struct packed {
      logic [6:0] funct7;
      logic [4:0] rs2;
      logic [4:0] rs1;
      logic [2:0] funct3;
      logic [4:0] rd;
      opcode_t    opcode;
   } instr_t;

   // EX operand source: register file, MEM-stage ALU result, WB write data
   typedef enum logic [1:0] {
      FWD_RF  = 2'd0,
      FWD_MEM = 2'd1,
      FWD_WB  = 2'd2
   } fwd_sel_t;

   typedef enum logic [2:0] {
      ST_RUN       = 3'd0,
      ST_LD_STALL  = 3'd1,
      ST_BR_FLUSH  = 3'd2,
      ST_INT_DRAIN = 3'd3,
      ST_INT_REDIR = 3'd4
   } pctl_state_t;

   // PC mux encodings understood by the PC module
   localparam logic [2:0] PCSEL_SEQ    = 3'd0;
   localparam logic [2:0] PCSEL_JALR   = 3'd1;
   localparam logic [2:0] PCSEL_BRANCH = 3'd2;
   localparam logic [2:0] PCSEL_JAL    = 3'd3;
   localparam logic [2:0] PCSEL_TRAP   = 3'd4;

   // Counter wide enough to hold the larger sequence length with headroom
   function automatic int cnt_width(input int a, input int b);
      int m;
      m = (a > b) ? a : b;
      return $clog2(m) + 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/otter_pipe_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : otter_pipe_ctrl_if
//  Description : Stage-status inputs and control outputs of the hazard
//                controller. The controller uses the slave view; the core
//                (stage registers, PC module) uses the master view.
//  Revision    : 1.0 - initial release
// ============================================================================
interface otter_pipe_ctrl_if #(
   parameter int PCSEL_W = 3
);
   import otter_pipe_ctrl_pkg::*;

   logic [4:0]         de_rs1_addr;
   logic               de_rs1_used;
   logic [4:0]         de_rs2_addr;
   logic               de_rs2_used;
   logic [31:0]        de_pc;
   logic [4:0]         ex_rd_addr;
   logic               ex_regWrite;
   logic               ex_memRead2;
   logic [4:0]         ex_rs1_addr;
   logic [4:0]         ex_rs2_addr;
   logic [4:0]         mem_rd_addr;
   logic               mem_regWrite;
   logic [4:0]         wb_rd_addr;
   logic               wb_regWrite;
   logic [PCSEL_W-1:0] ex_pc_sel;
   logic               intr;
   logic               mie;

   logic               pc_write;
   logic               if_flush;
   logic               de_flush;
   logic [PCSEL_W-1:0] pc_source;
   fwd_sel_t           fwd_a_sel;
   fwd_sel_t           fwd_b_sel;
   logic               int_taken;
   logic [31:0]        mepc;

   modport slave (
      input  de_rs1_addr, de_rs1_used, de_rs2_addr, de_rs2_used, de_pc,
      input  ex_rd_addr, ex_regWrite, ex_memRead2, ex_rs1_addr, ex_rs2_addr,
      input  mem_rd_addr, mem_regWrite, wb_rd_addr, wb_regWrite,
      input  ex_pc_sel, intr, mie,
      output pc_write, if_flush, de_flush, pc_source,
      output fwd_a_sel, fwd_b_sel, int_taken, mepc
   );

   modport master (
      output de_rs1_addr, de_rs1_used, de_rs2_addr, de_rs2_used, de_pc,
      output ex_rd_addr, ex_regWrite, ex_memRead2, ex_rs1_addr, ex_rs2_addr,
      output mem_rd_addr, mem_regWrite, wb_rd_addr, wb_regWrite,
      output ex_pc_sel, intr, mie,
      input  pc_write, if_flush, de_flush, pc_source,
      input  fwd_a_sel, fwd_b_sel, int_taken, mepc
   );

endinterface
`default_nettype wire

// File: rtl/otter_pipe_ctrl_fwd_unit.sv
`default_nettype none
// ============================================================================
//  Module      : otter_pipe_ctrl_fwd_unit
//  Description : Operand forwarding select for one EX source register.
//                The younger MEM result wins over WB; x0 never forwards.
//  Revision    : 1.0 - initial release
// ============================================================================
module otter_pipe_ctrl_fwd_unit
   import otter_pipe_ctrl_pkg::*;
(
   input  wire [4:0] i_ex_rs,
   input  wire [4:0] i_mem_rd,
   input  wire       i_mem_regwrite,
   input  wire [4:0] i_wb_rd,
   input  wire       i_wb_regwrite,
   output fwd_sel_t  o_sel
);

   // Pick the most recent producer of i_ex_rs still in flight
   always_comb begin
      o_sel = FWD_RF;
      if (i_mem_regwrite && (i_mem_rd != 5'd0) && (i_mem_rd == i_ex_rs)) begin
         o_sel = FWD_MEM;
      end else if (i_wb_regwrite && (i_wb_rd != 5'd0) && (i_wb_rd == i_ex_rs)) begin
         o_sel = FWD_WB;
      end
   end

endmodule
`default_nettype wire

// File: rtl/otter_pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : otter_pipe_ctrl
//  Description : Hazard controller for the 5-stage OTTER core. Sequences
//                load-use stalls, redirect flushes and interrupt entry, and
//                drives the forwarding selects for both EX operands.
//  Revision    : 1.0 - initial release
// ============================================================================
module otter_pipe_ctrl
   import otter_pipe_ctrl_pkg::*;
#(
   parameter int                 FLUSH_CYCLES = 2,
   parameter int                 DRAIN_CYCLES = 3,
   parameter int                 PCSEL_W      = 3,
   parameter logic [PCSEL_W-1:0] PCSEL_MTVEC  = PCSEL_W'(PCSEL_TRAP)
)(
   input wire               CLK,
   input wire               RESET,
   otter_pipe_ctrl_if.slave bus
);

   localparam int                    CNT_W         = cnt_width(FLUSH_CYCLES, DRAIN_CYCLES);
   localparam logic [CNT_W-1:0]      c_flush_load  = CNT_W'(FLUSH_CYCLES - 1);
   localparam logic [CNT_W-1:0]      c_drain_load  = CNT_W'(DRAIN_CYCLES - 1);
   localparam logic [CNT_W-1:0]      c_cnt_one     = CNT_W'(1);
   // A one-cycle sequence is fully covered by its entry cycle
   localparam pctl_state_t           c_flush_next  = (FLUSH_CYCLES > 1) ? ST_BR_FLUSH  : ST_RUN;
   localparam pctl_state_t           c_drain_next  = (DRAIN_CYCLES > 1) ? ST_INT_DRAIN : ST_INT_REDIR;

   pctl_state_t        r_state;
   pctl_state_t        w_state_nxt;
   logic [CNT_W-1:0]   r_cnt;
   logic [CNT_W-1:0]   w_cnt_nxt;
   logic [CNT_W-1:0]   w_cnt_dec;
   logic [31:0]        r_mepc;
   logic [31:0]        w_mepc_nxt;
   logic               w_load_use;
   logic               w_pc_write;
   logic               w_if_flush;
   logic               w_de_flush;
   logic [PCSEL_W-1:0] w_pc_source;
   logic               w_int_taken;
   fwd_sel_t           w_fwd_a;
   fwd_sel_t           w_fwd_b;

   otter_pipe_ctrl_fwd_unit u_fwd_a (
      .i_ex_rs        (bus.ex_rs1_addr),
      .i_mem_rd       (bus.mem_rd_addr),
      .i_mem_regwrite (bus.mem_regWrite),
      .i_wb_rd        (bus.wb_rd_addr),
      .i_wb_regwrite  (bus.wb_regWrite),
      .o_sel          (w_fwd_a)
   );

   otter_pipe_ctrl_fwd_unit u_fwd_b (
      .i_ex_rs        (bus.ex_rs2_addr),
      .i_mem_rd       (bus.mem_rd_addr),
      .i_mem_regwrite (bus.mem_regWrite),
      .i_wb_rd        (bus.wb_rd_addr),
      .i_wb_regwrite  (bus.wb_regWrite),
      .o_sel          (w_fwd_b)
   );

   // A load in EX whose destination is read by the instruction behind it
   assign w_load_use = bus.ex_memRead2 && bus.ex_regWrite && (bus.ex_rd_addr != 5'd0) &&
                       ((bus.de_rs1_used && (bus.de_rs1_addr == bus.ex_rd_addr)) ||
                        (bus.de_rs2_used && (bus.de_rs2_addr == bus.ex_rd_addr)));

   assign w_cnt_dec = r_cnt - c_cnt_one;

   // State, sequence counter and captured return PC
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_state <= ST_RUN;
         r_cnt   <= '0;
         r_mepc  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_mepc  <= w_mepc_nxt;
      end
   end

   // Next state and per-cycle pipeline controls; reset forces idle controls
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_mepc_nxt  = r_mepc;
      w_pc_write  = 1'b1;
      w_if_flush  = 1'b0;
      w_de_flush  = 1'b0;
      w_pc_source = '0;
      w_int_taken = 1'b0;
      if (!RESET) begin
         case (r_state)
            ST_RUN: begin
               if (bus.ex_pc_sel != '0) begin
                  w_pc_source = bus.ex_pc_sel;
                  w_if_flush  = 1'b1;
                  w_de_flush  = 1'b1;
                  w_cnt_nxt   = c_flush_load;
                  w_state_nxt = c_flush_next;
               end else if (w_load_use) begin
                  w_pc_write  = 1'b0;
                  w_de_flush  = 1'b1;
                  w_state_nxt = ST_LD_STALL;
               end else if (bus.intr && bus.mie) begin
                  w_mepc_nxt  = bus.de_pc;
                  w_pc_write  = 1'b0;
                  w_de_flush  = 1'b1;
                  w_cnt_nxt   = c_drain_load;
                  w_state_nxt = c_drain_next;
               end
            end
            ST_LD_STALL: begin
               // bubble already in EX; hazard is gone, resume
               w_state_nxt = ST_RUN;
            end
            ST_BR_FLUSH: begin
               w_if_flush = 1'b1;
               w_de_flush = 1'b1;
               w_cnt_nxt  = w_cnt_dec;
               if (w_cnt_dec == '0) begin
                  w_state_nxt = ST_RUN;
               end
            end
            ST_INT_DRAIN: begin
               w_pc_write = 1'b0;
               w_de_flush = 1'b1;
               w_cnt_nxt  = w_cnt_dec;
               if (w_cnt_dec == '0) begin
                  w_state_nxt = ST_INT_REDIR;
               end
            end
            ST_INT_REDIR: begin
               w_pc_source = PCSEL_MTVEC;
               w_int_taken = 1'b1;
               w_if_flush  = 1'b1;
               w_de_flush  = 1'b1;
               w_cnt_nxt   = c_flush_load;
               w_state_nxt = c_flush_next;
            end
            default: begin
               w_state_nxt = ST_RUN;
               w_cnt_nxt   = '0;
            end
         endcase
      end
   end

   assign bus.pc_write  = w_pc_write;
   assign bus.if_flush  = w_if_flush;
   assign bus.de_flush  = w_de_flush;
   assign bus.pc_source = w_pc_source;
   assign bus.int_taken = w_int_taken;
   assign bus.mepc      = r_mepc;
   assign bus.fwd_a_sel = RESET ? FWD_RF : w_fwd_a;
   assign bus.fwd_b_sel = RESET ? FWD_RF : w_fwd_b;

endmodule
`default_nettype wire
